// File: rtl/sequence_generator.sv
// Serial pattern transmitter: shifts a captured PAT_W-bit pattern out MSB-first,
// repeat_cnt times, with optional idle-zero gaps between repetitions.
module sequence_generator #(
  parameter int PAT_W   = 3,
  parameter int CNT_W   = 4,
  parameter int GAP_LEN = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [PAT_W-1:0] pattern_i,
  input  logic [CNT_W-1:0] repeat_cnt_i,
  output logic             x_o,
  output logic             x_valid_o,
  output logic             frame_start_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int BIT_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam int GAP_W = (GAP_LEN > 0) ? $clog2(GAP_LEN + 1) : 1;
  localparam logic [BIT_W-1:0] BIT_MSB  = BIT_W'(PAT_W - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_LEN > 0) ? GAP_W'(GAP_LEN - 1) : {GAP_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             x_q, x_d;
  logic             xv_q, xv_d;
  logic             fs_q, fs_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [BIT_W-1:0] bit_dec_s;

  assign bit_dec_s = bit_q - BIT_W'(1);

  // Next-state and next-output logic; outputs default to the idle value of 0.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    rep_d   = rep_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    x_d     = 1'b0;
    xv_d    = 1'b0;
    fs_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    if (abort_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i && (repeat_cnt_i != {CNT_W{1'b0}})) begin
            state_d = ST_SHIFT;
            pat_d   = pattern_i;
            rep_d   = repeat_cnt_i;
            bit_d   = BIT_MSB;
            x_d     = pattern_i[PAT_W-1];
            xv_d    = 1'b1;
            fs_d    = 1'b1;
            busy_d  = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (bit_q != {BIT_W{1'b0}}) begin
            bit_d  = bit_dec_s;
            x_d    = pat_q[bit_dec_s];
            xv_d   = 1'b1;
            busy_d = 1'b1;
          end else if (rep_q > CNT_W'(1)) begin
            rep_d = rep_q - CNT_W'(1);
            if (GAP_LEN > 0) begin
              state_d = ST_GAP;
              gap_d   = GAP_LAST;
              busy_d  = 1'b1;
            end else begin
              bit_d  = BIT_MSB;
              x_d    = pat_q[PAT_W-1];
              xv_d   = 1'b1;
              fs_d   = 1'b1;
              busy_d = 1'b1;
            end
          end else begin
            // Final bit of the final repetition has just been shown.
            state_d = ST_IDLE;
            rep_d   = {CNT_W{1'b0}};
            done_d  = 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_q == {GAP_W{1'b0}}) begin
            state_d = ST_SHIFT;
            bit_d   = BIT_MSB;
            x_d     = pat_q[PAT_W-1];
            xv_d    = 1'b1;
            fs_d    = 1'b1;
            busy_d  = 1'b1;
          end else begin
            gap_d  = gap_q - GAP_W'(1);
            busy_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, datapath and registered outputs with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      pat_q   <= {PAT_W{1'b0}};
      rep_q   <= {CNT_W{1'b0}};
      bit_q   <= {BIT_W{1'b0}};
      gap_q   <= {GAP_W{1'b0}};
      x_q     <= 1'b0;
      xv_q    <= 1'b0;
      fs_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      rep_q   <= rep_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      x_q     <= x_d;
      xv_q    <= xv_d;
      fs_q    <= fs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign x_o           = x_q;
  assign x_valid_o     = xv_q;
  assign frame_start_o = fs_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Bench for sequence_generator: two instances (GAP_LEN=0 and GAP_LEN=2) share stimulus;
// per-cycle expected output tuples are queued on start and popped every cycle.
module tb_sequence_generator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] pattern = 3'b000;
  logic [3:0] reps = 4'd0;
  logic       x0, v0, f0, b0, d0;
  logic       x2, v2, f2, b2, d2;

  sequence_generator #(.PAT_W(3), .CNT_W(4), .GAP_LEN(0)) u_gap0 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
    .pattern_i(pattern), .repeat_cnt_i(reps),
    .x_o(x0), .x_valid_o(v0), .frame_start_o(f0), .busy_o(b0), .done_o(d0)
  );

  sequence_generator #(.PAT_W(3), .CNT_W(4), .GAP_LEN(2)) u_gap2 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
    .pattern_i(pattern), .repeat_cnt_i(reps),
    .x_o(x2), .x_valid_o(v2), .frame_start_o(f2), .busy_o(b2), .done_o(d2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] pat;
    logic [3:0] reps;
    int         busy0;
    int         busy2;
  } vec_t;

  vec_t       vecs[7];
  logic [4:0] q0[$];
  logic [4:0] q2[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         bc0 = 0;
  int         bc2 = 0;
  string      tag = "init";

  // Expected tuple layout: {x, x_valid, frame_start, busy, done}
  task automatic push_xfer(input logic [2:0] p, input int r, input int gap);
    logic [4:0] e;
    for (int k = 0; k < r; k++) begin
      for (int b = 2; b >= 0; b--) begin
        e = {p[b], 1'b1, (b == 2), 1'b1, 1'b0};
        if (gap == 0) q0.push_back(e); else q2.push_back(e);
      end
      if (k < r - 1) begin
        for (int g = 0; g < gap; g++) begin
          if (gap == 0) q0.push_back(5'b00010); else q2.push_back(5'b00010);
        end
      end
    end
    if (r > 0) begin
      if (gap == 0) q0.push_back(5'b00001); else q2.push_back(5'b00001);
    end
  endtask

  task automatic push_both(input logic [2:0] p, input int r);
    push_xfer(p, r, 0);
    push_xfer(p, r, 2);
  endtask

  task automatic check_vec(input string nm, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s %s cyc=%0d got=%b exp=%b", tag, nm, cyc, got, exp);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s %s got=%0d exp=%0d", tag, nm, got, exp);
    end
  endtask

  task automatic step();
    logic [4:0] e0;
    logic [4:0] e2;
    @(posedge clk);
    #1;
    cyc++;
    e0 = 5'b00000;
    e2 = 5'b00000;
    if (q0.size() > 0) e0 = q0.pop_front();
    if (q2.size() > 0) e2 = q2.pop_front();
    check_vec("gap0", {x0, v0, f0, b0, d0}, e0);
    check_vec("gap2", {x2, v2, f2, b2, d2}, e2);
    if (b0 === 1'b1) bc0++;
    if (b2 === 1'b1) bc2++;
  endtask

  task automatic drain(input int limit);
    for (int i = 0; i < limit && (q0.size() > 0 || q2.size() > 0); i++) begin
      step();
    end
    checks++;
    if (q0.size() > 0 || q2.size() > 0) begin
      failures++;
      $display("FAIL %s timeout left0=%0d left2=%0d exp=0", tag, q0.size(), q2.size());
      q0.delete();
      q2.delete();
    end
  endtask

  initial begin
    vecs[0] = '{pat: 3'b101, reps: 4'd1,  busy0: 3,  busy2: 3};
    vecs[1] = '{pat: 3'b101, reps: 4'd3,  busy0: 9,  busy2: 13};
    vecs[2] = '{pat: 3'b110, reps: 4'd2,  busy0: 6,  busy2: 8};
    vecs[3] = '{pat: 3'b011, reps: 4'd15, busy0: 45, busy2: 73};
    vecs[4] = '{pat: 3'b000, reps: 4'd1,  busy0: 3,  busy2: 3};
    vecs[5] = '{pat: 3'b111, reps: 4'd0,  busy0: 0,  busy2: 0};
    vecs[6] = '{pat: 3'b010, reps: 4'd2,  busy0: 6,  busy2: 8};

    tag = "reset";
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();

    for (int i = 0; i < 7; i++) begin
      tag = $sformatf("vec%0d", i);
      pattern = vecs[i].pat;
      reps = vecs[i].reps;
      start = 1'b1;
      bc0 = 0;
      bc2 = 0;
      push_both(vecs[i].pat, int'(vecs[i].reps));
      step();
      start = 1'b0;
      drain(200);
      step();
      check_int("busy_cycles_gap0", bc0, vecs[i].busy0);
      check_int("busy_cycles_gap2", bc2, vecs[i].busy2);
    end

    tag = "midstart";
    pattern = 3'b101;
    reps = 4'd2;
    start = 1'b1;
    push_both(3'b101, 2);
    step();
    start = 1'b0;
    step();
    pattern = 3'b000;
    reps = 4'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    drain(100);
    step();

    tag = "abort";
    pattern = 3'b110;
    reps = 4'd3;
    start = 1'b1;
    push_both(3'b110, 3);
    step();
    start = 1'b0;
    repeat (4) step();
    abort = 1'b1;
    q0.delete();
    q2.delete();
    step();
    abort = 1'b0;
    repeat (3) step();

    tag = "abort_start";
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    repeat (4) step();

    tag = "rst_gap";
    pattern = 3'b101;
    reps = 4'd2;
    start = 1'b1;
    push_both(3'b101, 2);
    step();
    start = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    q0.delete();
    q2.delete();
    step();
    rst = 1'b0;
    step();

    tag = "b2b";
    pattern = 3'b110;
    reps = 4'd1;
    start = 1'b1;
    push_both(3'b110, 1);
    step();
    start = 1'b0;
    repeat (3) step();
    pattern = 3'b011;
    start = 1'b1;
    push_both(3'b011, 1);
    step();
    start = 1'b0;
    drain(50);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
